// File: rtl/dm_responder.sv
// dm_responder: data-memory slave with programmable wait states, byte-enabled stores
// and a registered valid/ready response channel.
module dm_responder #(
    parameter int ADDR_W      = 6,
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [31:0]       ReqWData,
    input  logic [3:0]        ReqByteEn,
    output logic              RspValid,
    input  logic              RspReady,
    output logic [31:0]       RspRData,
    output logic              RspErr,
    output logic              Busy
);
    localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
    state_t state, stateNext;
    logic [3:0] cnt;
    logic writeQ;
    logic [ADDR_W-1:0] addrQ;
    logic [31:0] wDataQ;
    logic [3:0] byteEnQ;
    logic [31:0] mem [DEPTH];
    logic inRange;
    logic [IDX_W-1:0] memIdx;
    // Widen by one bit so DEPTH == 2**ADDR_W compares correctly.
    assign inRange = {1'b0, addrQ} < (ADDR_W + 1)'(DEPTH);
    assign memIdx = addrQ[IDX_W-1:0];
    assign ReqReady = state == IDLE;
    assign Busy = state != IDLE;
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (ReqValid) stateNext = WAIT_CYCLES == 0 ? ACCESS : WAIT;
            WAIT:    if (cnt == 4'd0) stateNext = ACCESS;
            ACCESS:  stateNext = RESP;
            RESP:    if (RspReady) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            writeQ   <= 1'b0;
            addrQ    <= '0;
            wDataQ   <= 32'd0;
            byteEnQ  <= 4'd0;
            RspValid <= 1'b0;
            RspRData <= 32'd0;
            RspErr   <= 1'b0;
        end else begin
            state <= stateNext;
            if (state == IDLE && ReqValid) begin
                writeQ  <= ReqWrite;
                addrQ   <= ReqAddr;
                wDataQ  <= ReqWData;
                byteEnQ <= ReqByteEn;
                cnt     <= WAIT_INIT;
            end
            if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (state == ACCESS) begin
                RspValid <= 1'b1;
                RspErr   <= !inRange;
                RspRData <= (inRange && !writeQ) ? mem[memIdx] : 32'd0;
            end
            if (state == RESP && RspReady) RspValid <= 1'b0;
        end
    end
    // The array is never reset; gating on RST drops a store whose ACCESS edge meets reset.
    always_ff @(posedge CLK) begin
        if (RST && state == ACCESS && writeQ && inRange)
            for (int i = 0; i < 4; i++)
                if (byteEnQ[i]) mem[memIdx][8*i +: 8] <= wDataQ[8*i +: 8];
    end
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed and randomized checks of dm_responder against a word-array model,
// using a WAIT_CYCLES=2 instance (a*) and a WAIT_CYCLES=0 instance (b*).
module tb_dm_responder;
    logic clk = 0, rst = 0;
    logic aReqValid = 0, aReqReady, aReqWrite = 0, aRspValid, aRspReady = 0, aRspErr, aBusy;
    logic [5:0] aReqAddr = 0;
    logic [31:0] aReqWData = 0, aRspRData;
    logic [3:0] aReqByteEn = 0;
    logic bReqValid = 0, bReqReady, bReqWrite = 0, bRspValid, bRspReady = 0, bRspErr, bBusy;
    logic [5:0] bReqAddr = 0;
    logic [31:0] bReqWData = 0, bRspRData;
    logic [3:0] bReqByteEn = 0;
    logic [31:0] modelA [32];
    logic [31:0] modelB [32];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    dm_responder #(.ADDR_W(6), .DEPTH(32), .WAIT_CYCLES(2)) dutA (
        .CLK(clk), .RST(rst), .ReqValid(aReqValid), .ReqReady(aReqReady), .ReqWrite(aReqWrite),
        .ReqAddr(aReqAddr), .ReqWData(aReqWData), .ReqByteEn(aReqByteEn), .RspValid(aRspValid),
        .RspReady(aRspReady), .RspRData(aRspRData), .RspErr(aRspErr), .Busy(aBusy));
    dm_responder #(.ADDR_W(6), .DEPTH(32), .WAIT_CYCLES(0)) dutB (
        .CLK(clk), .RST(rst), .ReqValid(bReqValid), .ReqReady(bReqReady), .ReqWrite(bReqWrite),
        .ReqAddr(bReqAddr), .ReqWData(bReqWData), .ReqByteEn(bReqByteEn), .RspValid(bRspValid),
        .RspReady(bRspReady), .RspRData(bRspRData), .RspErr(bRspErr), .Busy(bBusy));

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic void modelAccess(input bit wr, input int addr, input logic [31:0] wd,
                                        input logic [3:0] be, output logic [31:0] rd, output logic err);
        err = addr >= 32;
        rd = 32'd0;
        if (!err) begin
            if (wr) modelA[addr] = merge(modelA[addr], wd, be);
            else rd = modelA[addr];
        end
    endfunction

    // One transaction on instance A; ok reports response stability while held and a clean return to idle.
    task automatic txnA(input bit wr, input int addr, input logic [31:0] wd, input logic [3:0] be,
                        input int hold, input bit poke, output logic [31:0] rd, output logic err,
                        output int lat, output bit ok);
        @(negedge clk);
        aReqValid = 1; aReqWrite = wr; aReqAddr = 6'(addr); aReqWData = wd; aReqByteEn = be; aRspReady = 0;
        @(posedge clk);
        @(negedge clk);
        aReqValid = 0;
        lat = 0;
        while (!aRspValid && lat < 50) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        rd = aRspRData; err = aRspErr; ok = 1;
        if (poke) begin
            aReqValid = 1; aReqWrite = 1; aReqAddr = 6'd9; aReqWData = 32'h0; aReqByteEn = 4'hF;
        end
        repeat (hold) begin
            @(posedge clk); @(negedge clk);
            if (!aRspValid || aRspRData !== rd || aRspErr !== err || aReqReady !== 1'b0) ok = 0;
        end
        aReqValid = 0; aRspReady = 1;
        @(posedge clk); @(negedge clk);
        aRspReady = 0;
        if (aRspValid !== 1'b0 || aReqReady !== 1'b1 || aBusy !== 1'b0) ok = 0;
    endtask

    // Runs one transaction on A and compares every observed field with the model.
    task automatic runA(input string name, input bit wr, input int addr, input logic [31:0] wd,
                        input logic [3:0] be, input int hold, input bit poke);
        logic [31:0] rd, erd;
        logic err, eerr;
        int lat;
        bit ok;
        txnA(wr, addr, wd, be, hold, poke, rd, err, lat, ok);
        modelAccess(wr, addr, wd, be, erd, eerr);
        checks++;
        if (lat != 3 || rd !== erd || err !== eerr || !ok) begin
            errors++;
            $display("FAIL %s: lat=%0d rdata=%h err=%b ok=%0d, expected lat=3 rdata=%h err=%b ok=1",
                     name, lat, rd, err, ok, erd, eerr);
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({aReqReady, aRspValid, aRspErr, aBusy} !== 4'b1000 || aRspRData !== 32'd0) begin
            errors++;
            $display("FAIL reset_a: ready/valid/err/busy=%b rdata=%h, expected 1000 rdata=0",
                     {aReqReady, aRspValid, aRspErr, aBusy}, aRspRData);
        end
        checks++;
        if ({bReqReady, bRspValid, bRspErr, bBusy} !== 4'b1000 || bRspRData !== 32'd0) begin
            errors++;
            $display("FAIL reset_b: ready/valid/err/busy=%b rdata=%h, expected 1000 rdata=0",
                     {bReqReady, bRspValid, bRspErr, bBusy}, bRspRData);
        end
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    task automatic test_basic;
        runA("basic_store", 1, 3, 32'hDEADBEEF, 4'hF, 0, 0);
        runA("basic_load", 0, 3, 32'h0, 4'h0, 0, 0);
        checks++;
        if (modelA[3] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_model: got %h expected deadbeef", modelA[3]);
        end
    endtask

    task automatic test_byte_lanes;
        logic [31:0] rd;
        logic err;
        int lat;
        bit ok;
        runA("lanes_fill", 1, 7, 32'hFFFFFFFF, 4'hF, 0, 0);
        runA("lanes_store", 1, 7, 32'h00A5005A, 4'b0101, 0, 0);
        txnA(0, 7, 0, 0, 0, 0, rd, err, lat, ok);
        checks++;
        if (rd !== 32'hFFA5FF5A || err !== 1'b0) begin
            errors++;
            $display("FAIL lanes_load: got %h err=%b expected ffa5ff5a err=0", rd, err);
        end
        runA("lanes_none_store", 1, 7, 32'h11111111, 4'h0, 0, 0);
        txnA(0, 7, 0, 0, 0, 0, rd, err, lat, ok);
        checks++;
        if (rd !== 32'hFFA5FF5A) begin
            errors++;
            $display("FAIL lanes_none_load: got %h expected ffa5ff5a", rd);
        end
    endtask

    task automatic test_out_of_range;
        logic [31:0] rd;
        logic err;
        int lat;
        bit ok;
        runA("oor_fill8", 1, 8, 32'h0BADCAFE, 4'hF, 0, 0);
        txnA(0, 40, 0, 0, 0, 0, rd, err, lat, ok);
        checks++;
        if (rd !== 32'd0 || err !== 1'b1) begin
            errors++;
            $display("FAIL oor_load: got %h err=%b expected 0 err=1", rd, err);
        end
        runA("oor_store", 1, 40, 32'h55555555, 4'hF, 0, 0);
        runA("oor_alias_load8", 0, 8, 0, 0, 0, 0);
    endtask

    task automatic test_backpressure;
        runA("bp_fill9", 1, 9, 32'hCAFEF00D, 4'hF, 0, 0);
        runA("bp_hold_load", 0, 3, 0, 0, 5, 1);
        runA("bp_ignored_store", 0, 9, 0, 0, 0, 0);
    endtask

    task automatic test_reset_wait;
        bit spurious = 0;
        runA("rw_prewrite", 1, 5, 32'h0, 4'hF, 0, 0);
        @(negedge clk);
        aReqValid = 1; aReqWrite = 1; aReqAddr = 6'd5; aReqWData = 32'h12345678; aReqByteEn = 4'hF;
        @(posedge clk);
        @(negedge clk);
        aReqValid = 0;
        #2 rst = 0;
        #1;
        checks++;
        if ({aReqReady, aRspValid, aBusy} !== 3'b100) begin
            errors++;
            $display("FAIL rw_async_reset: ready/valid/busy=%b expected 100", {aReqReady, aRspValid, aBusy});
        end
        @(negedge clk);
        rst = 1;
        repeat (6) begin
            @(negedge clk);
            if (aRspValid !== 1'b0) spurious = 1;
        end
        checks++;
        if (spurious) begin
            errors++;
            $display("FAIL rw_spurious_rsp: RspValid seen 1 expected 0");
        end
        runA("rw_load5", 0, 5, 0, 0, 0, 0);
    endtask

    task automatic test_random;
        for (int a = 0; a < 32; a++) runA("rand_fill", 1, a, $urandom, 4'hF, 0, 0);
        for (int n = 0; n < 40; n++)
            runA("rand_op", 1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom,
                 4'($urandom_range(0, 15)), $urandom_range(0, 3), 0);
    endtask

    task automatic test_back_to_back;
        bit opWr [16];
        int opAddr [16], accCyc [16];
        logic [31:0] opData [16], expRd [16];
        logic [3:0] opBe [16];
        int issued = 0, got = 0, cyc = 0;
        for (int i = 0; i < 16; i++) begin
            opWr[i] = i < 8;
            opAddr[i] = i < 8 ? i : 15 - i;
            opData[i] = $urandom;
            opBe[i] = i == 0 ? 4'hF : 4'($urandom_range(0, 15));
            modelB[i % 8] = i < 8 ? 32'd0 : modelB[i % 8];
        end
        bRspReady = 1;
        while (got < 16 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (issued == 16) bReqValid = 0;
            if (bRspValid) begin
                checks++;
                if (bRspRData !== expRd[got] || bRspErr !== 1'b0 || cyc - accCyc[got] != 2) begin
                    errors++;
                    $display("FAIL b2b_rsp%0d: rdata=%h err=%b delay=%0d expected rdata=%h err=0 delay=2",
                             got, bRspRData, bRspErr, cyc - accCyc[got], expRd[got]);
                end
                got++;
            end
            if (bReqReady && issued < 16) begin
                bReqValid = 1; bReqWrite = opWr[issued]; bReqAddr = 6'(opAddr[issued]);
                bReqWData = opData[issued]; bReqByteEn = opBe[issued];
                // Unwritten lanes of a first store are unknown in the DUT; only fully-enabled data is trusted.
                if (opWr[issued]) begin
                    modelB[opAddr[issued]] = merge(issued == 0 ? 32'd0 : modelB[opAddr[issued]],
                                                   opData[issued], opBe[issued]);
                    expRd[issued] = 32'd0;
                end else expRd[issued] = modelB[opAddr[issued]];
                accCyc[issued] = cyc;
                if (issued > 0) begin
                    checks++;
                    if (cyc - accCyc[issued-1] != 3) begin
                        errors++;
                        $display("FAIL b2b_period%0d: got %0d cycles expected 3", issued, cyc - accCyc[issued-1]);
                    end
                end
                issued++;
            end
        end
        bReqValid = 0; bRspReady = 0;
        checks++;
        if (got != 16) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d responses expected 16", got);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_byte_lanes;
        test_out_of_range;
        test_backpressure;
        test_reset_wait;
        test_random;
        test_back_to_back_fixup;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Store addresses 0..7 with full lanes first so every later load has a defined expectation.
    task automatic test_back_to_back_fixup;
        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            bReqValid = 1; bReqWrite = 1; bReqAddr = 6'(a); bReqWData = 32'd0; bReqByteEn = 4'hF; bRspReady = 1;
            @(posedge clk);
            @(negedge clk);
            bReqValid = 0;
            repeat (2) @(negedge clk);
        end
        bRspReady = 0;
        @(negedge clk);
        test_back_to_back;
    endtask
endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder for the core's load/store port.
- The core issues word requests over a valid/ready request channel.
- This block stalls for a programmable number of wait states, performs the read or byte-enabled write on an internal word array, then returns a response over a valid/ready response channel.
- Forms the slave end of the data-memory interface and replaces the zero-latency data memory once the core gains stall support.

Parameters:
- ADDR_W, 6, width of the word address (request address is a word index, not a byte address).
- DEPTH, 32, number of implemented 32-bit words; valid addresses are 0..DEPTH-1, DEPTH <= 2**ADDR_W.
- WAIT_CYCLES, 2, wait states between request accept and array access (0..15).

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- ReqValid  input  1  request present.
- ReqReady  output  1  block can accept a request this cycle.
- ReqWrite  input  1  1 = store, 0 = load.
- ReqAddr  input  ADDR_W  word address.
- ReqWData  input  32  store data.
- ReqByteEn  input  4  store byte lanes; bit i enables bits 8i+7..8i.
- RspValid  output  1  response present.
- RspReady  input  1  core accepts the response.
- RspRData  output  32  load data; 0 for stores and errors.
- RspErr  output  1  address >= DEPTH.
- Busy  output  1  any state other than IDLE.

Behaviour:
- Reset (RST=0, asynchronous):
  - State goes to IDLE. ReqReady=1, RspValid=0, RspRData=0, RspErr=0, Busy=0.
  - Latched request fields and the wait counter clear.
  - The array is not reset.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - ReqReady=1.
  - On ReqValid=1 at an edge, latch ReqWrite, ReqAddr, ReqWData and ReqByteEn.
  - If WAIT_CYCLES=0, go to ACCESS; else load the counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT:
  - ReqReady=0. Decrement the counter each edge; when the counter = 0, go to ACCESS.
  - Request inputs are ignored and the latched copy is used.
- ACCESS (one cycle), on the edge leaving ACCESS:
  - Address in range, store: write only the enabled lanes of mem[addr]; other lanes are unchanged. RspRData<=0, RspErr<=0.
  - Address in range, load: RspRData<=mem[addr], RspErr<=0.
  - Address out of range: no array write, RspRData<=0, RspErr<=1.
  - A store with ReqByteEn=0 still produces a normal response and leaves the array unchanged.
  - Next state is RESP.
- RESP:
  - RspValid=1. RspRData and RspErr hold stable until the handshake.
  - On RspReady=1, go to IDLE and clear RspValid.
  - A new request can be accepted no earlier than the cycle after the response handshake (no overlap; ReqReady=0 in RESP).
- Latency: if a request is accepted at edge k, RspValid rises after edge k+WAIT_CYCLES+1. Throughput is one transaction per WAIT_CYCLES+3 cycles with RspReady held at 1.
- ReqReady is a function of state only, with no combinational path from ReqValid. RspValid is registered.
- Reset mid-transaction: the pending request is dropped.
  - A store is committed only if its ACCESS edge completed before RST fell.
  - No response is emitted for a dropped request.
- ReqValid may deassert without acceptance; there is no requirement that ReqValid stay asserted while ReqReady=0.
- Busy=1 in WAIT, ACCESS and RESP.

Test Plan:
- Reset during WAIT: store 0x12345678 to addr 5 with byte-enables 1111, assert RST=0 during WAIT, release, then load addr 5 -> the load returns the pre-store content (bench pre-writes 0x0), with no spurious RspValid.
- Basic store/load, WAIT_CYCLES=2, RspReady=1:
  - Store 0xDEADBEEF, byte-enables 1111, to addr 3 -> RspValid 3 edges after accept, RspRData=0, RspErr=0.
  - Load addr 3 -> RspRData=0xDEADBEEF.
- Byte lanes: addr 7 = 0xFFFFFFFF, store 0x00A5005A with byte-enables 0101 -> a load returns 0xFFA5FF5A. A store with byte-enables 0000 leaves the word unchanged.
- Out-of-range: load addr 40 with DEPTH=32 -> RspErr=1, RspRData=0. A store to addr 40 must not alias onto addr 8; a load of addr 8 is unchanged.
- Response backpressure: hold RspReady=0 for 5 cycles -> RspValid and RspRData stable, ReqReady=0, and a new ReqValid is ignored. RspReady=1 -> IDLE next edge.
- WAIT_CYCLES=0 build: back-to-back loads with RspReady=1 -> response 1 edge after accept, one transaction every 3 cycles.
